can_bit_timing_detect: RTL and testbench

Parametrised successor to the CAN frame detector. It synchronises `can_rx` and detects bus idle (IDLE_BITS consecutive recessive bit samples) and start of frame (first dominant edge while idle). It also generates a per-bit sample strobe with hard resynchronisation on recessive-to-dominant edges. It sits between the CAN pin and the bit-level receive logic (destuffer/data sampler), which consumes `sample_en`/`rx_bit` and the `sof`/`frame_end` framing pulses.

---
 rtl/can_pkg.sv | 34 +++
 rtl/can_rx_filter.sv | 45 ++++
 rtl/can_bit_timing_detect.sv | 150 +++++++++++++++
 tb/tb_can_bit_timing_detect.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared definitions for the CAN receive blocks: detector states, bit-timing
// constant functions and parameter range checks.
package can_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        FRAME     = 2'd2
    } can_state_e;

    function automatic int unsigned bit_clks(input int unsigned clk_mhz,
                                             input int unsigned rate_khz);
        return (clk_mhz * 1000) / rate_khz;
    endfunction

    function automatic int unsigned sample_clks(input int unsigned pct,
                                                input int unsigned bclks);
        return (pct * bclks) / 100;
    endfunction

    // Width of a counter that must hold 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic bit params_ok(input int unsigned bclks,
                                     input int unsigned pct,
                                     input int unsigned idle_bits,
                                     input int unsigned filter_len);
        return (bclks >= 8) && (pct >= 50) && (pct <= 90) &&
               (idle_bits >= 1) && (idle_bits <= 31) && (filter_len >= 1);
    endfunction

endpackage

// File: rtl/can_rx_filter.sv
// Glitch filter for the synchronised CAN receive line: the output follows the
// input only after FILTER_LEN consecutive cycles of the new level.
module can_rx_filter
    import can_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_o
);

    localparam int unsigned CNT_W = cnt_width(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (rx_i == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            out_d = rx_i;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            out_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign rx_o = out_q;

endmodule

// File: rtl/can_bit_timing_detect.sv
// CAN bus idle / start-of-frame detector with bit sample strobe and hard resync.
// Optional input glitch filter enabled by defining CAN_RX_GLITCH_FILTER_EN.
module can_bit_timing_detect
    import can_pkg::*;
#(
    parameter int unsigned clk_speed_MHz    = 100,
    parameter int unsigned can_bit_rate_KHz = 1000,
    parameter int unsigned SAMPLE_PCT       = 75,
    parameter int unsigned IDLE_BITS        = 11,
    parameter int unsigned FILTER_LEN       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic can_rx,
    output logic sof,
    output logic frame_end,
    output logic bus_idle,
    output logic in_frame,
    output logic sample_en,
    output logic rx_bit
);

    localparam int unsigned BIT_CLKS    = bit_clks(clk_speed_MHz, can_bit_rate_KHz);
    localparam int unsigned SAMPLE_CLKS = sample_clks(SAMPLE_PCT, BIT_CLKS);
    localparam int unsigned BIT_W       = cnt_width(BIT_CLKS - 1);
    localparam int unsigned REC_W       = cnt_width(IDLE_BITS);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_CLKS - 1);
    localparam logic [BIT_W-1:0] TICK_AT  = BIT_W'(SAMPLE_CLKS - 1);
    localparam logic [REC_W-1:0] REC_MAX  = REC_W'(IDLE_BITS);
    localparam logic [REC_W-1:0] REC_LAST = REC_W'(IDLE_BITS - 1);

    if (!params_ok(BIT_CLKS, SAMPLE_PCT, IDLE_BITS, FILTER_LEN)) begin : g_param_error
        $error("can_bit_timing_detect: timing parameters out of range");
    end

    logic sync1_q, sync2_q, rx_s, rx_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= can_rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= rx_s;
        end
    end

`ifdef CAN_RX_GLITCH_FILTER_EN
    can_rx_filter #(.FILTER_LEN(FILTER_LEN)) u_rx_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_i  (sync2_q),
        .rx_o  (rx_s)
    );
`else
    assign rx_s = sync2_q;
`endif

    can_state_e       state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [REC_W-1:0] rec_cnt_q, rec_cnt_d;
    logic             sof_q, sof_d, frame_end_q, frame_end_d;
    logic             bus_idle_q, in_frame_q;
    logic             sample_en_q, sample_en_d, rx_bit_q, rx_bit_d;
    logic             fall, tick, rec_full;

    always_comb begin
        fall     = rx_prev_q & ~rx_s;
        tick     = (bit_cnt_q == TICK_AT);
        // Only a recessive tick can complete the run, so a fall on a tick never ends a frame.
        rec_full = tick & rx_s & (rec_cnt_q == REC_LAST);

        state_d     = state_q;
        sof_d       = 1'b0;
        frame_end_d = 1'b0;
        unique case (state_q)
            WAIT_IDLE: if (rec_full) state_d = IDLE;
            IDLE: begin
                if (fall) begin
                    state_d = FRAME;
                    sof_d   = 1'b1;
                end
            end
            FRAME: begin
                if (rec_full) begin
                    state_d     = IDLE;
                    frame_end_d = 1'b1;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase

        if (sof_d || (state_q == FRAME && fall)) begin
            bit_cnt_d = '0;
        end else if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
        end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        rec_cnt_d = rec_cnt_q;
        if (state_d != state_q) begin
            rec_cnt_d = '0;
        end else if (tick) begin
            if (!rx_s) begin
                rec_cnt_d = '0;
            end else if (rec_cnt_q != REC_MAX) begin
                rec_cnt_d = rec_cnt_q + 1'b1;
            end
        end

        sample_en_d = (state_q == FRAME) & tick;
        rx_bit_d    = sample_en_d ? rx_s : rx_bit_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT_IDLE;
            bit_cnt_q   <= '0;
            rec_cnt_q   <= '0;
            sof_q       <= 1'b0;
            frame_end_q <= 1'b0;
            bus_idle_q  <= 1'b0;
            in_frame_q  <= 1'b0;
            sample_en_q <= 1'b0;
            rx_bit_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rec_cnt_q   <= rec_cnt_d;
            sof_q       <= sof_d;
            frame_end_q <= frame_end_d;
            bus_idle_q  <= (state_d == IDLE);
            in_frame_q  <= (state_d == FRAME);
            sample_en_q <= sample_en_d;
            rx_bit_q    <= rx_bit_d;
        end
    end

    assign sof       = sof_q;
    assign frame_end = frame_end_q;
    assign bus_idle  = bus_idle_q;
    assign in_frame  = in_frame_q;
    assign sample_en = sample_en_q;
    assign rx_bit    = rx_bit_q;

endmodule

// File: tb/tb_can_bit_timing_detect.sv
// Scoreboard bench for can_bit_timing_detect at default timing (100 clocks/bit,
// sample at 75, 11 idle bits); follows CAN_RX_GLITCH_FILTER_EN when defined.
module tb_can_bit_timing_detect;

    localparam int FLEN = 4;
`ifdef CAN_RX_GLITCH_FILTER_EN
    localparam int L = 2 + FLEN;
`else
    localparam int L = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic can_rx = 1'b1;
    logic sof, frame_end, bus_idle, in_frame, sample_en, rx_bit;

    can_bit_timing_detect #(
        .clk_speed_MHz    (100),
        .can_bit_rate_KHz (1000),
        .SAMPLE_PCT       (75),
        .IDLE_BITS        (11),
        .FILTER_LEN       (FLEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .can_rx    (can_rx),
        .sof       (sof),
        .frame_end (frame_end),
        .bus_idle  (bus_idle),
        .in_frame  (in_frame),
        .sample_en (sample_en),
        .rx_bit    (rx_bit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   c;
        logic b;
    } se_t;

    int  sof_exp[$];
    int  fe_exp[$];
    se_t se_exp[$];
    int  tests = 0;
    int  fails = 0;

    // Every output pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        int   e;
        se_t  s;
        if (sof === 1'b1) begin
            tests++;
            if (sof_exp.size() == 0) begin
                fails++;
                $display("FAIL sof_unexpected: pulse at cycle %0d, required none", cyc);
            end else begin
                e = sof_exp.pop_front();
                if (cyc !== e) begin
                    fails++;
                    $display("FAIL sof_cycle: got cycle %0d, required %0d", cyc, e);
                end
            end
        end
        if (frame_end === 1'b1) begin
            tests++;
            if (fe_exp.size() == 0) begin
                fails++;
                $display("FAIL frame_end_unexpected: pulse at cycle %0d, required none", cyc);
            end else begin
                e = fe_exp.pop_front();
                if (cyc !== e) begin
                    fails++;
                    $display("FAIL frame_end_cycle: got cycle %0d, required %0d", cyc, e);
                end
            end
        end
        if (sample_en === 1'b1) begin
            tests++;
            if (se_exp.size() == 0) begin
                fails++;
                $display("FAIL sample_en_unexpected: pulse at cycle %0d bit %b, required none", cyc, rx_bit);
            end else begin
                s = se_exp.pop_front();
                if (cyc !== s.c || rx_bit !== s.b) begin
                    fails++;
                    $display("FAIL sample_en: got cycle %0d bit %b, required cycle %0d bit %b",
                             cyc, rx_bit, s.c, s.b);
                end
            end
        end
    end

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_se(input int c, input logic b);
        se_t s;
        s.c = c;
        s.b = b;
        se_exp.push_back(s);
    endtask

    task automatic test_reset();
        int r;
        rst_n  = 1'b0;
        can_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({sof, frame_end, bus_idle, in_frame, sample_en, rx_bit} !== 6'b000001) begin
            fails++;
            $display("FAIL reset_outputs: got %b, required 000001",
                     {sof, frame_end, bus_idle, in_frame, sample_en, rx_bit});
        end
        rst_n = 1'b1;
        r = cyc;
        go(r + 1074);
        tests++;
        if (bus_idle !== 1'b0) begin
            fails++;
            $display("FAIL idle_early: bus_idle %b at cycle %0d, required 0", bus_idle, cyc);
        end
        go(r + 1075);
        tests++;
        if (bus_idle !== 1'b1 || in_frame !== 1'b0) begin
            fails++;
            $display("FAIL idle_rise: bus_idle %b in_frame %b, required 1 0", bus_idle, in_frame);
        end
        go(r + 1080);
        tests++;
        if (sof_exp.size() + fe_exp.size() + se_exp.size() != 0) begin
            fails++;
            $display("FAIL reset_pending: %0d expected events not seen, required 0",
                     sof_exp.size() + fe_exp.size() + se_exp.size());
        end
    endtask

    task automatic test_sof();
        int t, s;
        t = cyc;
        s = t + L + 1;
        sof_exp.push_back(s);
        push_se(s + 75, 1'b0);
        for (int k = 1; k <= 11; k++) push_se(s + 75 + 100 * k, 1'b1);
        fe_exp.push_back(s + 1175);
        can_rx = 1'b0;
        go(s - 1);
        tests++;
        if (in_frame !== 1'b0) begin
            fails++;
            $display("FAIL sof_in_frame_early: got %b, required 0", in_frame);
        end
        go(s);
        tests++;
        if (in_frame !== 1'b1 || bus_idle !== 1'b0) begin
            fails++;
            $display("FAIL sof_levels: in_frame %b bus_idle %b, required 1 0", in_frame, bus_idle);
        end
        go(t + 100);
        can_rx = 1'b1;
        go(s + 1175);
        tests++;
        if (bus_idle !== 1'b1 || in_frame !== 1'b0) begin
            fails++;
            $display("FAIL sof_frame_end_levels: bus_idle %b in_frame %b, required 1 0",
                     bus_idle, in_frame);
        end
        go(s + 1180);
        tests++;
        if (sof_exp.size() + fe_exp.size() + se_exp.size() != 0) begin
            fails++;
            $display("FAIL sof_pending: %0d expected events not seen, required 0",
                     sof_exp.size() + fe_exp.size() + se_exp.size());
        end
    endtask

    task automatic test_resync();
        int t, s;
        t = cyc;
        s = t + L + 1;
        sof_exp.push_back(s);
        push_se(s + 75, 1'b0);
        push_se(s + 175, 1'b1);
        push_se(s + 285, 1'b0);
        for (int m = 1; m <= 11; m++) push_se(s + 285 + 100 * m, 1'b1);
        fe_exp.push_back(s + 1385);
        can_rx = 1'b0;
        go(t + 100);
        can_rx = 1'b1;
        go(t + 210);
        can_rx = 1'b0;
        go(s + 275);
        tests++;
        if (sample_en !== 1'b0) begin
            fails++;
            $display("FAIL resync_old_grid: sample_en %b at cycle %0d, required 0", sample_en, cyc);
        end
        go(t + 310);
        can_rx = 1'b1;
        go(s + 1390);
        tests++;
        if (sof_exp.size() + fe_exp.size() + se_exp.size() != 0) begin
            fails++;
            $display("FAIL resync_pending: %0d expected events not seen, required 0",
                     sof_exp.size() + fe_exp.size() + se_exp.size());
        end
    endtask

    task automatic test_fall_on_tick();
        int t, s;
        t = cyc;
        s = t + L + 1;
        sof_exp.push_back(s);
        push_se(s + 75, 1'b0);
        for (int k = 1; k <= 10; k++) push_se(s + 75 + 100 * k, 1'b1);
        push_se(s + 1175, 1'b0);
        push_se(s + 1250, 1'b0);
        for (int m = 1; m <= 11; m++) push_se(s + 1250 + 100 * m, 1'b1);
        fe_exp.push_back(s + 2350);
        can_rx = 1'b0;
        go(t + 100);
        can_rx = 1'b1;
        // Dominant edge lands on the eleventh recessive sample point.
        go(s + 1174 - L);
        can_rx = 1'b0;
        go(s + 1175);
        tests++;
        if (frame_end !== 1'b0 || in_frame !== 1'b1) begin
            fails++;
            $display("FAIL fall_on_tick: frame_end %b in_frame %b, required 0 1", frame_end, in_frame);
        end
        go(t + 1275);
        can_rx = 1'b1;
        go(s + 2355);
        tests++;
        if (sof_exp.size() + fe_exp.size() + se_exp.size() != 0) begin
            fails++;
            $display("FAIL fall_on_tick_pending: %0d expected events not seen, required 0",
                     sof_exp.size() + fe_exp.size() + se_exp.size());
        end
    endtask

    task automatic test_back_to_back();
        int t, s, t2, s2;
        logic [3:0] pat;
        pat = 4'b0010;
        t  = cyc;
        s  = t + L + 1;
        t2 = t + 1476;
        s2 = s + 1476;
        sof_exp.push_back(s);
        for (int k = 0; k < 4; k++) push_se(s + 75 + 100 * k, pat[k]);
        for (int k = 4; k <= 14; k++) push_se(s + 75 + 100 * k, 1'b1);
        fe_exp.push_back(s + 1475);
        sof_exp.push_back(s2);
        push_se(s2 + 75, 1'b0);
        for (int k = 1; k <= 11; k++) push_se(s2 + 75 + 100 * k, 1'b1);
        fe_exp.push_back(s2 + 1175);
        for (int k = 0; k < 4; k++) begin
            can_rx = pat[k];
            go(t + 100 * (k + 1));
        end
        can_rx = 1'b1;
        go(t2);
        can_rx = 1'b0;
        go(s + 1475);
        tests++;
        if (frame_end !== 1'b1 || bus_idle !== 1'b1 || in_frame !== 1'b0 || sof !== 1'b0) begin
            fails++;
            $display("FAIL b2b_frame_end: fe %b idle %b in_frame %b sof %b, required 1 1 0 0",
                     frame_end, bus_idle, in_frame, sof);
        end
        go(s2);
        tests++;
        if (sof !== 1'b1 || in_frame !== 1'b1) begin
            fails++;
            $display("FAIL b2b_sof: sof %b in_frame %b, required 1 1", sof, in_frame);
        end
        go(t2 + 100);
        can_rx = 1'b1;
        go(s2 + 1180);
        tests++;
        if (sof_exp.size() + fe_exp.size() + se_exp.size() != 0) begin
            fails++;
            $display("FAIL b2b_pending: %0d expected events not seen, required 0",
                     sof_exp.size() + fe_exp.size() + se_exp.size());
        end
    endtask

    task automatic test_glitch();
        int t, s, w;
`ifdef CAN_RX_GLITCH_FILTER_EN
        t = cyc;
        can_rx = 1'b0;
        go(t + FLEN - 1);
        can_rx = 1'b1;
        go(t + 200);
        tests++;
        if (in_frame !== 1'b0 || bus_idle !== 1'b1) begin
            fails++;
            $display("FAIL glitch_filtered: in_frame %b bus_idle %b, required 0 1", in_frame, bus_idle);
        end
        w = FLEN;
`else
        w = 1;
`endif
        t = cyc;
        s = t + L + 1;
        sof_exp.push_back(s);
        for (int k = 0; k <= 10; k++) push_se(s + 75 + 100 * k, 1'b1);
        fe_exp.push_back(s + 1075);
        can_rx = 1'b0;
        go(t + w);
        can_rx = 1'b1;
        go(s);
        tests++;
        if (in_frame !== 1'b1) begin
            fails++;
            $display("FAIL glitch_sof: in_frame %b, required 1", in_frame);
        end
        go(s + 1080);
        tests++;
        if (sof_exp.size() + fe_exp.size() + se_exp.size() != 0) begin
            fails++;
            $display("FAIL glitch_pending: %0d expected events not seen, required 0",
                     sof_exp.size() + fe_exp.size() + se_exp.size());
        end
    endtask

    task automatic test_reset_midframe();
        int t, s, r;
        t = cyc;
        s = t + L + 1;
        sof_exp.push_back(s);
        push_se(s + 75, 1'b0);
        can_rx = 1'b0;
        go(t + 100);
        can_rx = 1'b1;
        go(t + 150);
        rst_n = 1'b0;
        go(t + 151);
        rst_n = 1'b1;
        r = cyc;
        tests++;
        if ({sof, frame_end, bus_idle, in_frame, sample_en, rx_bit} !== 6'b000001) begin
            fails++;
            $display("FAIL midframe_reset_outputs: got %b, required 000001",
                     {sof, frame_end, bus_idle, in_frame, sample_en, rx_bit});
        end
        go(r + 1074);
        tests++;
        if (bus_idle !== 1'b0) begin
            fails++;
            $display("FAIL midframe_idle_early: bus_idle %b, required 0", bus_idle);
        end
        go(r + 1075);
        tests++;
        if (bus_idle !== 1'b1) begin
            fails++;
            $display("FAIL midframe_idle_rise: bus_idle %b, required 1", bus_idle);
        end
        go(r + 1080);
        tests++;
        if (sof_exp.size() + fe_exp.size() + se_exp.size() != 0) begin
            fails++;
            $display("FAIL midframe_pending: %0d expected events not seen, required 0",
                     sof_exp.size() + fe_exp.size() + se_exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_sof();
        test_resync();
        test_fall_on_tick();
        test_back_to_back();
        test_glitch();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
